ps2_key_sequencer: RTL and testbench

PS2_KEY_SEQUENCER -- requirements
Module: ps2_key_sequencer

---
 rtl/ps2_pkg.sv | 45 ++++
 rtl/ps2_evt_fifo.sv | 65 ++++++
 rtl/ps2_key_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_ps2_key_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 key sequencer:
//   - ps2_state_t : prefix-decoder FSM states
//   - PFX_EXT/PFX_BRK : extended (E0) and break (F0) prefix bytes
//   - ps2_evt_t   : decoded event {ext, brk, code[7:0]} (10 bits)
//   - KEY_TABLE   : the 8 tracked keys as {ext, code}, index = key_held bit
//   - key_mask()  : one-hot key_held mask for an event (0 if untracked)
// -----------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  localparam int EVT_W = $bits(ps2_evt_t);

  // {ext, code}: W, A, S, D, up, down, left, right
  localparam logic [8:0] KEY_TABLE [8] = '{
    9'h01D, 9'h01C, 9'h01B, 9'h023,
    9'h175, 9'h172, 9'h16B, 9'h174
  };

  function automatic logic [7:0] key_mask(input ps2_evt_t ev);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (KEY_TABLE[i] == {ev.ext, ev.code}) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// -----------------------------------------------------------------------------
// ps2_evt_fifo
// Synchronous FIFO, DEPTH entries (power of two) of WIDTH bits.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset (empties the FIFO)
//   wr_en, wr_data : push request; accepted when not full, or when full and a
//                    pop happens on the same cycle
//   rd_en          : pop request; ignored when empty
//   rd_data        : head entry, forced to 0 while empty
//   full, empty    : occupancy flags
// -----------------------------------------------------------------------------
module ps2_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign do_rd = rd_en && !empty;
  // When full, a same-cycle pop frees the head slot, which is exactly the slot
  // wr_ptr points at, so the write lands there safely.
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_sequencer.sv
// -----------------------------------------------------------------------------
// ps2_key_sequencer
// Turns a stream of PS/2 scan bytes into {ext, brk, code} events, queues them
// in a small FIFO and keeps a live map of eight held keys.
// Optional feature (macro PS2_REPEAT_FILTER_EN): suppress typematic repeats,
// i.e. a make event for a tracked key that is already held is not queued.
// Ports:
//   clk_100mhz  : clock, rising edge
//   rst         : asynchronous active-high reset
//   scan_byte   : scan byte, qualified by the one-cycle strobe scan_valid
//   ev_data     : head event {ext, brk, code}, 0 when empty
//   ev_valid    : FIFO not empty
//   ev_ready    : consumer accept
//   key_held    : held map W, A, S, D, up, down, left, right (bits 0..7)
//   ovf         : one-cycle pulse when an event is dropped on a full FIFO
//   dbg_state   : current decoder state (ps2_state_t encoding)
// Handshake: an event transfers on a rising edge where ev_valid && ev_ready;
// while ev_valid is high and ev_ready is low, ev_data holds its value.
// Timing: final byte sampled at edge N -> event staged; at edge N+1 it is
// written to the FIFO and key_held is updated.
// -----------------------------------------------------------------------------
module ps2_key_sequencer
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic       clk_100mhz,
  input  logic       rst,
  input  logic [7:0] scan_byte,
  input  logic       scan_valid,
  output logic [9:0] ev_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] key_held,
  output logic       ovf,
  output logic [1:0] dbg_state
);

  localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;

  ps2_state_t  state;
  ps2_state_t  state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic        timeout_hit;
  logic        emit;
  ps2_evt_t    emit_evt;

  // Event staged at edge N, consumed at edge N+1.
  logic        evt_vld_q;
  ps2_evt_t    evt_q;
  logic [7:0]  evt_mask;
  logic        drop_repeat;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;

  assign dbg_state   = state;
  assign timeout_hit = (state != ST_IDLE) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // ---------------------------------------------------------------------------
  // Prefix decoder
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    emit_evt  = '0;
    if (scan_valid) begin
      case (state)
        ST_IDLE: begin
          if (scan_byte == PFX_EXT)      state_nxt = ST_EXT;
          else if (scan_byte == PFX_BRK) state_nxt = ST_BRK;
          else begin
            emit     = 1'b1;
            emit_evt = '{ext: 1'b0, brk: 1'b0, code: scan_byte};
          end
        end
        ST_EXT: begin
          if (scan_byte == PFX_EXT)      state_nxt = ST_EXT;
          else if (scan_byte == PFX_BRK) state_nxt = ST_EXT_BRK;
          else begin
            emit      = 1'b1;
            emit_evt  = '{ext: 1'b1, brk: 1'b0, code: scan_byte};
            state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (scan_byte == PFX_BRK)      state_nxt = ST_BRK;
          else if (scan_byte == PFX_EXT) state_nxt = ST_EXT_BRK;
          else begin
            emit      = 1'b1;
            emit_evt  = '{ext: 1'b0, brk: 1'b1, code: scan_byte};
            state_nxt = ST_IDLE;
          end
        end
        default: begin // ST_EXT_BRK
          if (scan_byte == PFX_EXT || scan_byte == PFX_BRK) state_nxt = ST_EXT_BRK;
          else begin
            emit      = 1'b1;
            emit_evt  = '{ext: 1'b1, brk: 1'b1, code: scan_byte};
            state_nxt = ST_IDLE;
          end
        end
      endcase
    end else if (timeout_hit) begin
      // A prefix that is never completed is abandoned silently.
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Inter-byte timeout: only meaningful while a prefix is pending.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst)                                              to_cnt <= '0;
    else if (scan_valid || state == ST_IDLE || timeout_hit) to_cnt <= '0;
    else                                                  to_cnt <= to_cnt + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Event staging, key map, repeat filter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      evt_vld_q <= 1'b0;
      evt_q     <= '0;
    end else begin
      evt_vld_q <= emit;
      evt_q     <= emit_evt;
    end
  end

  assign evt_mask = key_mask(evt_q);

`ifdef PS2_REPEAT_FILTER_EN
  assign drop_repeat = evt_vld_q && !evt_q.brk && ((evt_mask & key_held) != '0);
`else
  assign drop_repeat = 1'b0;
`endif

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      key_held <= '0;
    end else if (evt_vld_q) begin
      if (evt_q.brk) key_held <= key_held & ~evt_mask;
      else           key_held <= key_held | evt_mask;
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------
  assign push     = evt_vld_q && !drop_repeat;
  assign pop      = ev_valid && ev_ready;
  assign ev_valid = !fifo_empty;

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) ovf <= 1'b0;
    else     ovf <= push && fifo_full && !pop;
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk     (clk_100mhz),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (evt_q),
    .rd_en   (pop),
    .rd_data (ev_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ps2_key_sequencer
// Directed bench for ps2_key_sequencer. A short TIMEOUT_CYC keeps the timeout
// scenario brief. Inputs change on the falling edge; outputs are checked on
// the falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_ps2_key_sequencer;

  localparam int DEPTH = 4;
  localparam int TO    = 16;

  logic       clk_100mhz;
  logic       rst;
  logic [7:0] scan_byte;
  logic       scan_valid;
  logic [9:0] ev_data;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] key_held;
  logic       ovf;
  logic [1:0] dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [9:0] exp_q[$];

  ps2_key_sequencer #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .scan_byte  (scan_byte),
    .scan_valid (scan_valid),
    .ev_data    (ev_data),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .key_held   (key_held),
    .ovf        (ovf),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks (called on a falling edge) ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_100mhz);
  endtask

  // Byte sampled on the next rising edge; returns on the following falling edge.
  task automatic send_byte(input logic [7:0] b);
    scan_byte  = b;
    scan_valid = 1'b1;
    @(negedge clk_100mhz);
    scan_valid = 1'b0;
  endtask

  // Pop n entries, comparing each against the expected queue, then expect empty.
  task automatic drain(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_valid"}, ev_valid, 1);
      if (exp_q.size() > 0) check({tag, "_data"}, ev_data, exp_q.pop_front());
      else                  check({tag, "_sb_underflow"}, 1, 0);
      ev_ready = 1'b1;
      @(negedge clk_100mhz);
      ev_ready = 1'b0;
    end
    check({tag, "_empty"}, ev_valid, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst        = 1'b1;
    scan_byte  = 8'h00;
    scan_valid = 1'b0;
    ev_ready   = 1'b0;
    #3;
    check("rst_ev_valid", ev_valid, 0);
    check("rst_ev_data",  ev_data, 0);
    check("rst_key_held", key_held, 0);
    check("rst_ovf",      ovf, 0);
    check("rst_state",    dbg_state, 0);
    @(negedge clk_100mhz);
    rst = 1'b0;
    wait_cycles(1);

    // --- single make, consumer always ready ---
    ev_ready = 1'b1;
    send_byte(8'h1D);
    check("mk_latency_valid", ev_valid, 0);
    wait_cycles(1);
    check("mk_valid", ev_valid, 1);
    check("mk_data",  ev_data, 10'h01D);
    check("mk_held",  key_held, 8'h01);
    wait_cycles(1);
    check("mk_one_cycle", ev_valid, 0);
    ev_ready = 1'b0;

    // --- prefix combinations ---
    send_byte(8'hE0); send_byte(8'h75); exp_q.push_back(10'h275);
    wait_cycles(1);
    check("ext_make_held", key_held, 8'h11);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75); exp_q.push_back(10'h375);
    wait_cycles(1);
    check("ext_brk_held", key_held, 8'h01);
    send_byte(8'hF0); send_byte(8'h1D); exp_q.push_back(10'h11D);
    send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h72); exp_q.push_back(10'h372);
    wait_cycles(1);
    check("brk_held", key_held, 8'h00);
    drain("grp_a", 4);

    send_byte(8'hE0); send_byte(8'hE0); send_byte(8'h6B); exp_q.push_back(10'h26B);
    send_byte(8'h5A); exp_q.push_back(10'h05A);
    wait_cycles(1);
    check("untracked_held", key_held, 8'h40);
    send_byte(8'hF0); send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h6B);
    exp_q.push_back(10'h36B);
    wait_cycles(1);
    check("left_release", key_held, 8'h00);
    drain("grp_b", 3);

    // --- timeout after prefix ---
    send_byte(8'hE0);
    check("to_in_ext", dbg_state, 1);
    wait_cycles(TO + 4);
    check("to_back_idle", dbg_state, 0);
    send_byte(8'h1C); exp_q.push_back(10'h01C);
    send_byte(8'hE0);
    wait_cycles(TO - 3);
    check("to_still_ext", dbg_state, 1);
    send_byte(8'h74); exp_q.push_back(10'h274);
    wait_cycles(1);
    check("to_held", key_held, 8'h82);
    drain("grp_to", 2);
    send_byte(8'hF0); send_byte(8'h1C); exp_q.push_back(10'h11C);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74); exp_q.push_back(10'h374);
    wait_cycles(1);
    check("to_release", key_held, 8'h00);
    drain("grp_rel", 2);

    // --- overflow: five events into four slots ---
    send_byte(8'h15); exp_q.push_back(10'h015);
    send_byte(8'h16); exp_q.push_back(10'h016);
    send_byte(8'h1E); exp_q.push_back(10'h01E);
    send_byte(8'h26); exp_q.push_back(10'h026);
    wait_cycles(1);
    check("ovf_not_yet", ovf, 0);
    check("hold_head_a", ev_data, 10'h015);
    send_byte(8'h25);
    wait_cycles(1);
    check("ovf_pulse", ovf, 1);
    check("hold_head_b", ev_data, 10'h015);
    wait_cycles(1);
    check("ovf_one_cycle", ovf, 0);
    drain("grp_ovf", 4);

    // --- full FIFO with pop on the push cycle ---
    send_byte(8'h15); send_byte(8'h16); send_byte(8'h1E); send_byte(8'h26);
    wait_cycles(1);
    scan_byte  = 8'h25;
    scan_valid = 1'b1;
    @(negedge clk_100mhz);
    scan_valid = 1'b0;
    ev_ready   = 1'b1;
    check("pf_head", ev_data, 10'h015);
    @(negedge clk_100mhz);
    ev_ready = 1'b0;
    check("pf_no_ovf", ovf, 0);
    exp_q.push_back(10'h016);
    exp_q.push_back(10'h01E);
    exp_q.push_back(10'h026);
    exp_q.push_back(10'h025);
    wait_cycles(1);
    check("pf_no_ovf_late", ovf, 0);
    drain("grp_pf", 4);

    // --- typematic repeat ---
    send_byte(8'h1D); send_byte(8'h1D); send_byte(8'hF0); send_byte(8'h1D);
    exp_q.push_back(10'h01D);
`ifndef PS2_REPEAT_FILTER_EN
    exp_q.push_back(10'h01D);
`endif
    exp_q.push_back(10'h11D);
    wait_cycles(1);
    check("rep_ovf", ovf, 0);
    check("rep_held", key_held, 8'h00);
`ifdef PS2_REPEAT_FILTER_EN
    drain("grp_rep", 2);
`else
    drain("grp_rep", 3);
`endif

    // --- reset in the middle of a sequence ---
    send_byte(8'h1D); exp_q.push_back(10'h01D);
    wait_cycles(1);
    check("mid_pre_held", key_held, 8'h01);
    exp_q.delete();
    send_byte(8'hE0);
    #2 rst = 1'b1;
    #1;
    check("mid_async_state", dbg_state, 0);
    check("mid_async_held",  key_held, 8'h00);
    check("mid_async_valid", ev_valid, 0);
    @(negedge clk_100mhz);
    rst = 1'b0;
    wait_cycles(1);
    send_byte(8'h6B); exp_q.push_back(10'h06B);
    wait_cycles(1);
    check("mid_held_after", key_held, 8'h00);
    drain("grp_mid", 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
